lowpass_coefbank: RTL and testbench

- Double-buffered coefficient memory that answers the lowpass filter's coefficient fetch port (coefaddress in, coefdata out, same-cycle read).
- A host streams a new coefficient set into a shadow bank without disturbing filtering.
- The shadow bank becomes active on the next sample strobe (endata), so each output sample is computed with one consistent coefficient set.

---
 rtl/lowpass_coefbank.sv | 129 ++++++++++++
 tb/tb_lowpass_coefbank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lowpass_coefbank.sv
// Double-buffered coefficient bank for the lowpass filter: host loads a shadow set, swapped in on endata.
// Optional COEF_SYMMETRIC_EN: store only the first half of a symmetric tap set and mirror reads.
module lowpass_coefbank #(
  parameter int NTAPS = 65,
  parameter int CW    = 18,
  parameter int AW    = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] coefaddress,
  output logic [CW-1:0] coefdata,
  input  logic          endata,
  input  logic          load_start,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [CW-1:0] wr_data,
  output logic [AW-1:0] load_count,
  output logic          pending,
  output logic          active_bank,
  output logic          swap_done
);

`ifdef COEF_SYMMETRIC_EN
  localparam int DEPTH = (NTAPS + 1) / 2;
`else
  localparam int DEPTH = NTAPS;
`endif
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PENDING} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] bank0 [DEPTH];
  logic [CW-1:0] bank1 [DEPTH];
  logic          xfer;
  logic          swap;
  logic          last_word;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          rd_hit;

  assign wr_idx    = load_count[IW-1:0];
  assign last_word = (load_count == AW'(DEPTH - 1));
  assign pending   = (state == PENDING);

  always_comb begin
    state_nx = state;
    wr_ready = 1'b0;
    xfer     = 1'b0;
    swap     = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_nx = LOAD;
      end
      LOAD: begin
        wr_ready = (load_count < AW'(DEPTH));
        // A restart pulse wins over any word offered in the same cycle.
        if (!load_start && wr_valid && wr_ready) begin
          xfer = 1'b1;
          if (last_word) state_nx = PENDING;
        end
      end
      PENDING: begin
        if (load_start) begin
          state_nx = LOAD;
        end else if (endata) begin
          swap     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      load_count  <= '0;
      active_bank <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      state     <= state_nx;
      swap_done <= swap;
      if (swap) active_bank <= ~active_bank;
      if (load_start)  load_count <= '0;
      else if (xfer)   load_count <= load_count + 1'b1;
    end
  end

  // The shadow bank is always the one not currently being served.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (xfer) begin
      if (active_bank) bank0[wr_idx] <= wr_data;
      else             bank1[wr_idx] <= wr_data;
    end
  end

`ifdef COEF_SYMMETRIC_EN
  logic [AW-1:0] mirror;
  assign mirror = AW'(NTAPS - 1) - coefaddress;
`endif

  always_comb begin
    rd_hit   = 1'b0;
    rd_idx   = '0;
    coefdata = '0;
`ifdef COEF_SYMMETRIC_EN
    if (coefaddress < AW'(DEPTH)) begin
      rd_hit = 1'b1;
      rd_idx = coefaddress[IW-1:0];
    end else if (coefaddress < AW'(NTAPS)) begin
      rd_hit = 1'b1;
      rd_idx = mirror[IW-1:0];
    end
`else
    if (coefaddress < AW'(NTAPS)) begin
      rd_hit = 1'b1;
      rd_idx = coefaddress[IW-1:0];
    end
`endif
    if (rd_hit) coefdata = active_bank ? bank1[rd_idx] : bank0[rd_idx];
  end

endmodule

// File: tb/tb_lowpass_coefbank.sv
// Self-checking bench for lowpass_coefbank: vector table, directed sequences, random traffic vs. a set-level model.
module tb_lowpass_coefbank;
  localparam int NTAPS = 65;
  localparam int CW    = 18;
  localparam int AW    = 7;
`ifdef COEF_SYMMETRIC_EN
  localparam int NW  = (NTAPS + 1) / 2;
  localparam bit SYM = 1'b1;
`else
  localparam int NW  = NTAPS;
  localparam bit SYM = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic [AW-1:0] coefaddress;
  logic [CW-1:0] coefdata;
  logic          endata;
  logic          load_start;
  logic          wr_valid;
  logic          wr_ready;
  logic [CW-1:0] wr_data;
  logic [AW-1:0] load_count;
  logic          pending;
  logic          active_bank;
  logic          swap_done;

  lowpass_coefbank #(.NTAPS(NTAPS), .CW(CW), .AW(AW)) dut (
    .clock(clock), .reset(reset), .coefaddress(coefaddress), .coefdata(coefdata),
    .endata(endata), .load_start(load_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .load_count(load_count), .pending(pending),
    .active_bank(active_bank), .swap_done(swap_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the active set is kept as a full logical NTAPS-tap array; a load is a queue of host words.
  logic [CW-1:0] m_taps [NTAPS];
  logic [CW-1:0] m_q [$];
  bit m_loading, m_pend, m_act, m_sd;

  function automatic void model_reset();
    for (int a = 0; a < NTAPS; a++) m_taps[a] = '0;
    m_q.delete();
    m_loading = 0; m_pend = 0; m_act = 0; m_sd = 0;
  endfunction

  function automatic void model_step(input bit ls, input bit ed, input bit wv, input logic [CW-1:0] wd);
    m_sd = 0;
    if (ls) begin
      m_loading = 1; m_pend = 0; m_q.delete();
    end else if (m_loading) begin
      if (wv) begin
        m_q.push_back(wd);
        if (m_q.size() == NW) begin m_loading = 0; m_pend = 1; end
      end
    end else if (m_pend && ed) begin
      for (int a = 0; a < NTAPS; a++) m_taps[a] = (SYM && a >= NW) ? m_q[NTAPS-1-a] : m_q[a];
      m_act = ~m_act; m_pend = 0; m_sd = 1;
    end
  endfunction

  function automatic logic [CW-1:0] model_read(input int addr);
    return (addr < NTAPS) ? m_taps[addr] : '0;
  endfunction

  task automatic read_chk(input int addr, input logic [CW-1:0] exp, input string name);
    coefaddress = AW'(addr);
    #1;
    chk(name, coefdata, exp);
  endtask

  task automatic check_all();
    int addr;
    chk("wr_ready", wr_ready, m_loading);
    chk("load_count", load_count, m_q.size());
    chk("pending", pending, m_pend);
    chk("active_bank", active_bank, m_act);
    chk("swap_done", swap_done, m_sd);
    addr = $urandom_range(0, 127);
    read_chk(addr, model_read(addr), "coefdata_model");
  endtask

  task automatic cycle(input bit ls, input bit ed, input bit wv, input logic [CW-1:0] wd);
    load_start = ls; endata = ed; wr_valid = wv; wr_data = wd;
    @(posedge clock);
    model_step(ls, ed, wv, wd);
    #1;
    load_start = 0; endata = 0; wr_valid = 0;
    check_all();
  endtask

  task automatic realign();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [CW-1:0] ramp(input int i);
    return SYM ? CW'(i) : CW'(i + 1);
  endfunction

  typedef struct {
    bit ls; bit ed; bit wv;
    int exp_cnt; bit exp_rdy; bit exp_act; bit exp_sd;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{1, 0, 0, 0, 1, 0, 0},   // open load
      '{0, 0, 1, 1, 1, 0, 0},
      '{0, 0, 0, 1, 1, 0, 0},   // gap
      '{0, 0, 1, 2, 1, 0, 0},
      '{0, 0, 0, 2, 1, 0, 0},
      '{0, 1, 1, 3, 1, 0, 0},   // endata during load is ignored
      '{0, 1, 0, 3, 1, 0, 0},
      '{1, 0, 1, 0, 1, 0, 0},   // restart drops the word offered with it
      '{0, 0, 1, 1, 1, 0, 0},
      '{0, 0, 0, 1, 1, 0, 0}
    };

    reset = 0; coefaddress = '0; endata = 0; load_start = 0; wr_valid = 0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1;
    for (int a = 0; a < 128; a++) read_chk(a, '0, "reset_read");
    chk("reset_wr_ready", wr_ready, 0);
    chk("reset_pending", pending, 0);
    chk("reset_active", active_bank, 0);
    chk("reset_count", load_count, 0);
    chk("reset_swap_done", swap_done, 0);
    realign();

    foreach (tbl[i]) begin
      cycle(tbl[i].ls, tbl[i].ed, tbl[i].wv, CW'($urandom));
      chk("tbl_count", load_count, tbl[i].exp_cnt);
      chk("tbl_ready", wr_ready, tbl[i].exp_rdy);
      chk("tbl_active", active_bank, tbl[i].exp_act);
      chk("tbl_swap_done", swap_done, tbl[i].exp_sd);
    end

    // Full ramp load with an endata pulse at word 30.
    cycle(1, 0, 0, '0);
    for (int i = 0; i < NW; i++) begin
      cycle(0, i == 30, 1, ramp(i));
      if (i == 30) begin
        chk("load_endata_active", active_bank, 0);
        chk("load_endata_swap_done", swap_done, 0);
      end
    end
    chk("full_count", load_count, NW);
    chk("full_pending", pending, 1);
    chk("full_ready", wr_ready, 0);
    read_chk(5, '0, "shadow_hidden");
    cycle(0, 0, 1, 18'h00123);
    chk("extra_word_count", load_count, NW);
    cycle(0, 1, 0, '0);
    chk("swap_active", active_bank, 1);
    chk("swap_done_pulse", swap_done, 1);
    chk("swap_pending", pending, 0);
    cycle(0, 0, 0, '0);
    chk("swap_done_one_cycle", swap_done, 0);
    chk("count_holds", load_count, NW);
`ifdef COEF_SYMMETRIC_EN
    read_chk(40, 18'h00018, "sym_addr40");
    read_chk(32, 18'h00020, "sym_addr32");
    read_chk(5, 18'h00005, "sym_addr5");
`else
    read_chk(5, 18'h00006, "ramp_addr5");
    read_chk(64, 18'h00041, "ramp_addr64");
`endif
    read_chk(65, '0, "out_of_range");
    realign();

    // Restart after 10 words, then reload a constant set.
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, CW'($urandom));
    chk("partial_count", load_count, 10);
    cycle(1, 0, 0, '0);
    chk("restart_count", load_count, 0);
    for (int i = 0; i < NW; i++) cycle(0, 0, 1, 18'h3FFFD);
    cycle(0, 1, 0, '0);
    chk("const_active", active_bank, 0);
    for (int a = 0; a < NTAPS; a++) read_chk(a, 18'h3FFFD, "const_tap");
    realign();

    // load_start beats endata in PENDING.
    cycle(1, 0, 0, '0);
    for (int i = 0; i < NW; i++) cycle(0, 0, 1, CW'($urandom));
    chk("prio_pending_before", pending, 1);
    cycle(1, 1, 0, '0);
    chk("prio_active", active_bank, 0);
    chk("prio_swap_done", swap_done, 0);
    chk("prio_pending", pending, 0);
    chk("prio_count", load_count, 0);
    chk("prio_ready", wr_ready, 1);

    // Complete a swap, then reset in the middle of the next load.
    for (int i = 0; i < NW; i++) cycle(0, 0, 1, CW'($urandom));
    cycle(0, 1, 0, '0);
    chk("pre_reset_active", active_bank, 1);
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 40 && i < NW - 1; i++) cycle(0, 0, 1, CW'($urandom));
    #2 reset = 0;
    #1;
    model_reset();
    chk("midreset_active", active_bank, 0);
    chk("midreset_ready", wr_ready, 0);
    chk("midreset_pending", pending, 0);
    chk("midreset_count", load_count, 0);
    for (int a = 0; a < 128; a++) read_chk(a, '0, "midreset_read");
    repeat (2) @(posedge clock);
    #1 reset = 1;
    #1;

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0, CW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
